// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: one-bit-per-cycle shift-add multiplier / restoring divider with start/busy/done handshake.
// Define MULDIV_SIGNED_EN to add the signed_op port and two's-complement operation.
module seq_muldiv_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 multiply,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
`ifdef MULDIV_SIGNED_EN
    input  logic                 signed_op,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 divide_by_zero,
    output logic                 overflow
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mul_q, mul_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d, ovf_q, ovf_d;
    logic [WIDTH:0]     mul_sum, shifted, diff;
    logic [2*WIDTH-1:0] acc_step, fin_result;
    logic [WIDTH-1:0]   rem_step, fin_rem, mag_a, mag_b;
    logic               fin_ovf;
`ifdef MULDIV_SIGNED_EN
    logic               sgn_q, sgn_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [2*WIDTH-1:0] sprod;
    logic [WIDTH-1:0]   sq, sr;
    always_comb begin
        sgn_d   = sgn_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        if (state_q != CALC && start) begin
            sgn_d   = signed_op;
            neg_a_d = signed_op & operand_a[WIDTH-1];
            neg_b_d = signed_op & operand_b[WIDTH-1];
        end
        mag_a = neg_a_d ? -operand_a : operand_a;
        mag_b = neg_b_d ? -operand_b : operand_b;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) {sgn_q, neg_a_q, neg_b_q} <= '0;
        else {sgn_q, neg_a_q, neg_b_q} <= {sgn_d, neg_a_d, neg_b_d};
    // The unsigned core works on magnitudes; signs are reapplied on the final iteration.
    always_comb begin
        sprod      = (neg_a_q ^ neg_b_q) ? -acc_step : acc_step;
        sq         = (neg_a_q ^ neg_b_q) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        sr         = neg_a_q ? -rem_step : rem_step;
        fin_result = mul_q ? sprod : {{WIDTH{1'b0}}, sq};
        fin_rem    = mul_q ? '0 : sr;
        fin_ovf    = mul_q ? (sgn_q ? !(&sprod[2*WIDTH-1:WIDTH-1] || ~|sprod[2*WIDTH-1:WIDTH-1])
                                    : |sprod[2*WIDTH-1:WIDTH])
                           : (neg_a_q && neg_b_q && a_q == {1'b1, {(WIDTH-1){1'b0}}} && b_q == WIDTH'(1));
    end
`else
    always_comb begin
        mag_a      = operand_a;
        mag_b      = operand_b;
        fin_result = mul_q ? acc_step : {{WIDTH{1'b0}}, acc_step[WIDTH-1:0]};
        fin_rem    = mul_q ? '0 : rem_step;
        fin_ovf    = mul_q & |acc_step[2*WIDTH-1:WIDTH];
    end
`endif
    // Multiply keeps {sum, multiplier} in acc; divide keeps the quotient in acc's low half.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        shifted  = {rem_q, acc_q[WIDTH-1]};
        diff     = shifted - {1'b0, b_q};
        acc_step = mul_q ? {mul_sum, acc_q[WIDTH-1:1]}
                         : {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~diff[WIDTH]};
        rem_step = mul_q ? rem_q : (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]);
    end
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_d       = mul_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        if (state_q != CALC && start) begin
            mul_d = multiply;
            a_d   = mag_a;
            b_d   = mag_b;
            acc_d = {{WIDTH{1'b0}}, multiply ? mag_b : mag_a};
            rem_d = '0;
            cnt_d = '0;
            dbz_d = 1'b0;
            ovf_d = 1'b0;
            state_d = CALC;
            if (!multiply && operand_b == '0) begin
                state_d     = DONE;
                dbz_d       = 1'b1;
                result_d    = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                remainder_d = operand_a;
            end
        end else if (state_q == CALC) begin
            acc_d = acc_step;
            rem_d = rem_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                state_d     = DONE;
                result_d    = fin_result;
                remainder_d = fin_rem;
                ovf_d       = fin_ovf;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mul_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_q       <= mul_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end
    assign busy           = state_q == CALC;
    assign done           = state_q == DONE;
    assign result         = result_q;
    assign remainder      = remainder_q;
    assign divide_by_zero = dbz_q;
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_seq_muldiv_unit.sv
// tb_seq_muldiv_unit: directed vector table plus reset-abort sequence for seq_muldiv_unit (WIDTH=8).
module tb_seq_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        multiply = 1'b0;
    logic [7:0]  operand_a = '0;
    logic [7:0]  operand_b = '0;
    logic        signed_op = 1'b0;
    logic        busy, done, divide_by_zero, overflow;
    logic [15:0] result;
    logic [7:0]  remainder;
    int          n_cmp = 0;
    int          n_err = 0;

    seq_muldiv_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .multiply(multiply),
        .operand_a(operand_a), .operand_b(operand_b),
`ifdef MULDIV_SIGNED_EN
        .signed_op(signed_op),
`endif
        .busy(busy), .done(done), .result(result), .remainder(remainder),
        .divide_by_zero(divide_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mul;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sg;
        logic        poke;
        logic [15:0] res;
        logic [7:0]  rem;
        logic        dbz;
        logic        ovf;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_remainder"}, remainder, 0);
        chk({tag, "_dbz"}, divide_by_zero, 0);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    // Edges counted include the accepting edge: 9 for a full op, 1 for divide by zero.
    task automatic run_vec(input vec_t v, input int idx);
        int edges;
        int busy_cnt;
        string tag;
        tag = $sformatf("v%0d_%s_%0h_%0h", idx, v.mul ? "mul" : "div", v.a, v.b);
        @(negedge clk);
        start = 1'b1; multiply = v.mul; operand_a = v.a; operand_b = v.b; signed_op = v.sg;
        @(posedge clk); #1;
        start = 1'b0; multiply = ~v.mul; operand_a = 8'hA5; operand_b = 8'h5A; signed_op = ~v.sg;
        edges = 1;
        busy_cnt = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cnt++;
            start = v.poke && edges == 3;
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, edges, v.lat);
        chk({tag, "_busy_cycles"}, busy_cnt, v.lat == 1 ? 0 : 8);
        chk({tag, "_result"}, result, v.res);
        chk({tag, "_remainder"}, remainder, v.rem);
        chk({tag, "_dbz"}, divide_by_zero, v.dbz);
        chk({tag, "_ovf"}, overflow, v.ovf);
    endtask

    initial begin
        int seen;
        //                 mul   a      b      sg    poke  result    rem    dbz   ovf  lat
        vecs.push_back('{1'b1, 8'd13,  8'd11,  1'b0, 1'b0, 16'h008F, 8'h00, 1'b0, 1'b0, 9});
        vecs.push_back('{1'b1, 8'd200, 8'd3,   1'b0, 1'b0, 16'h0258, 8'h00, 1'b0, 1'b1, 9});
        vecs.push_back('{1'b1, 8'd255, 8'd255, 1'b0, 1'b0, 16'hFE01, 8'h00, 1'b0, 1'b1, 9});
        vecs.push_back('{1'b0, 8'd100, 8'd7,   1'b0, 1'b1, 16'h000E, 8'h02, 1'b0, 1'b0, 9});
        vecs.push_back('{1'b0, 8'd5,   8'd9,   1'b0, 1'b0, 16'h0000, 8'h05, 1'b0, 1'b0, 9});
        vecs.push_back('{1'b0, 8'd55,  8'd0,   1'b0, 1'b0, 16'h00FF, 8'h37, 1'b1, 1'b0, 1});
        vecs.push_back('{1'b1, 8'd7,   8'd6,   1'b0, 1'b0, 16'h002A, 8'h00, 1'b0, 1'b0, 9});
        vecs.push_back('{1'b1, 8'd0,   8'd200, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 9});
        vecs.push_back('{1'b1, 8'd16,  8'd16,  1'b0, 1'b0, 16'h0100, 8'h00, 1'b0, 1'b1, 9});
        vecs.push_back('{1'b1, 8'd15,  8'd17,  1'b0, 1'b0, 16'h00FF, 8'h00, 1'b0, 1'b0, 9});
        vecs.push_back('{1'b0, 8'd255, 8'd1,   1'b0, 1'b0, 16'h00FF, 8'h00, 1'b0, 1'b0, 9});
        vecs.push_back('{1'b0, 8'd200, 8'd200, 1'b0, 1'b0, 16'h0001, 8'h00, 1'b0, 1'b0, 9});
        vecs.push_back('{1'b0, 8'd254, 8'd255, 1'b0, 1'b0, 16'h0000, 8'hFE, 1'b0, 1'b0, 9});
`ifdef MULDIV_SIGNED_EN
        vecs.push_back('{1'b0, 8'hF9,  8'h02,  1'b1, 1'b0, 16'h00FD, 8'hFF, 1'b0, 1'b0, 9});
        vecs.push_back('{1'b0, 8'h80,  8'hFF,  1'b1, 1'b0, 16'h0080, 8'h00, 1'b0, 1'b1, 9});
        vecs.push_back('{1'b1, 8'hFD,  8'h05,  1'b1, 1'b0, 16'hFFF1, 8'h00, 1'b0, 1'b0, 9});
        vecs.push_back('{1'b1, 8'd64,  8'd2,   1'b1, 1'b0, 16'h0080, 8'h00, 1'b0, 1'b1, 9});
        vecs.push_back('{1'b1, 8'hFF,  8'hFF,  1'b1, 1'b0, 16'h0001, 8'h00, 1'b0, 1'b0, 9});
        vecs.push_back('{1'b0, 8'd7,   8'hFE,  1'b1, 1'b0, 16'h00FD, 8'h01, 1'b0, 1'b0, 9});
        vecs.push_back('{1'b0, 8'hF7,  8'h00,  1'b1, 1'b0, 16'h00FF, 8'hF7, 1'b1, 1'b0, 1});
        vecs.push_back('{1'b1, 8'd64,  8'd2,   1'b0, 1'b0, 16'h0080, 8'h00, 1'b0, 1'b0, 9});
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_idle_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);
        // Abort a 9*9 multiply with reset in its third cycle.
        @(negedge clk);
        start = 1'b1; multiply = 1'b1; operand_a = 8'd9; operand_b = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle_zero("midop_rst");
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1;
        end
        chk("midop_rst_no_done", seen, 0);
        run_vec('{1'b1, 8'd9, 8'd9, 1'b0, 1'b0, 16'h0051, 8'h00, 1'b0, 1'b0, 9}, 99);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
